iram_loader: RTL and testbench

- Writes a program image into the fetch stage's 8-word instruction RAM from a byte stream.
- Holds the processor in reset until the image is loaded and verified.
- The processor fetch path reads the iram; this block is the write side of that memory.
- Sits between a host byte source (bench or UART front end) and the `mips` top level. Drives the iram write port and the CPU reset.

---
 rtl/iram_loader.sv | 140 ++++++++++++++
 tb/tb_iram_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/iram_loader.sv
// Byte-stream loader for the fetch-stage instruction RAM.
// Keeps the core in reset until an image is written and its XOR checksum matches.
module iram_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [31:0]       iram_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        rx_cnt_q, rx_cnt_d;
  logic [7:0]        rx_nxt;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xfer;
  logic              room;

  assign byte_ready    = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer          = byte_valid && byte_ready;
  assign room          = (ww_q < DEPTH_W);
  assign rx_nxt        = rx_cnt_q + 8'd1;
  assign iram_we       = (state_q == S_WRITE) && room;
  assign iram_addr     = addr_q;
  assign iram_wdata    = word_q;
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign words_written = ww_q;
  // Core is released only from a clean DONE; any new start re-asserts reset via HDR.
  assign cpu_reset     = !((state_q == S_DONE) && !err_q);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    rx_cnt_d = rx_cnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    csum_d   = csum_q;
    err_d    = err_q;
    ww_d     = ww_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_HDR;
          n_d      = 8'd0;
          rx_cnt_d = 8'd0;
          idx_d    = 2'd0;
          csum_d   = 8'd0;
          err_d    = 1'b0;
          ww_d     = '0;
          addr_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          n_d     = byte_in;
          state_d = (byte_in == 8'd0) ? S_CHK : S_DATA;
          if (byte_in > DEPTH_B) err_d = 1'b1;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], byte_in};
          csum_d = csum_q ^ byte_in;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            if (room) addr_d = ww_q[ADDR_W-1:0];
          end
        end
      end
      S_WRITE: begin
        // Overflow words are still counted so the stream framing stays intact.
        if (room) ww_d = ww_q + ONE_W;
        rx_cnt_d = rx_nxt;
        state_d  = (rx_nxt < n_q) ? S_DATA : S_CHK;
      end
      S_CHK: begin
        if (xfer) begin
          if (byte_in != csum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= 8'd0;
      rx_cnt_q <= 8'd0;
      idx_q    <= 2'd0;
      word_q   <= 32'd0;
      csum_q   <= 8'd0;
      err_q    <= 1'b0;
      ww_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      rx_cnt_q <= rx_cnt_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
      ww_q     <= ww_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: expected iram writes go through a scoreboard queue.
module tb_iram_loader;
  logic        clock = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, iram_we, cpu_reset, done, err;
  logic [2:0]  iram_addr;
  logic [31:0] iram_wdata;
  logic [3:0]  words_written;

  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];
  logic [31:0] img[0:15];

  iram_loader #(.DEPTH(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .iram_we(iram_we),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata), .cpu_reset(cpu_reset),
    .done(done), .err(err), .words_written(words_written)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every iram_we pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset === 1'b0 && iram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {29'd0, iram_addr, iram_wdata}, 64'hdead);
      end else begin
        chk("write_addr_data", {29'd0, iram_addr, iram_wdata}, {29'd0, exp_q.pop_front()});
        chk("ready_low_on_we", 64'(byte_ready), 64'd0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit tog);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'(t), 64'd0);
    @(negedge clock);
    if (tog) begin
      byte_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("cpu_reset_after_start", 64'(cpu_reset), 64'd1);
  endtask

  // Streams header + nwords from img[] (+ checksum); csum_bad forces a zero checksum byte.
  task automatic stream(input logic [7:0] hdr, input int nwords, input bit csum_bad,
                        input bit tog, input int stop_after);
    logic [7:0] cs = 8'd0;
    logic [31:0] w;
    int sent = 0;
    for (int i = 0; i < nwords && i < 8; i++) exp_q.push_back({3'(i), img[i]});
    send(hdr, tog);
    for (int i = 0; i < nwords; i++) begin
      w = img[i];
      for (int k = 3; k >= 0; k--) begin
        if (stop_after >= 0 && sent == stop_after) begin
          byte_valid = 1'b0;
          return;
        end
        send(w[k*8 +: 8], tog);
        cs ^= w[k*8 +: 8];
        sent++;
      end
    end
    send(csum_bad ? 8'h00 : cs, tog);
    byte_valid = 1'b0;
  endtask

  task automatic check_end(input string tag, input bit e_err, input logic [3:0] e_ww);
    @(negedge clock);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(e_err));
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(e_err));
    chk({tag, "_words_written"}, 64'(words_written), 64'(e_ww));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_we", 64'(iram_we), 64'd0);
    chk("rst_addr_wdata", {29'd0, iram_addr, iram_wdata}, 64'd0);
    chk("rst_cpu_done_err", {61'd0, cpu_reset, done, err}, 64'b100);
    chk("rst_ww", 64'(words_written), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: two-word image, good checksum (0x20^0x08^0x05 = 0x2D)
    img[0] = 32'h20080005; img[1] = 32'h00000000;
    pulse_start();
    stream(8'h02, 2, 1'b0, 1'b0, -1);
    check_end("t1", 1'b0, 4'd2);
    chk("t1_addr_hold", 64'(iram_addr), 64'd1);

    // 2: same image, bad checksum
    pulse_start();
    stream(8'h02, 2, 1'b1, 1'b0, -1);
    check_end("t2", 1'b1, 4'd2);

    // 3: ten words, only eight land in the iram
    for (int i = 0; i < 10; i++) img[i] = {4{8'(8'h11 * (i + 1))}};
    pulse_start();
    stream(8'h0A, 10, 1'b0, 1'b0, -1);
    check_end("t3", 1'b1, 4'd8);

    // 4: empty image
    pulse_start();
    stream(8'h00, 0, 1'b0, 1'b0, -1);
    check_end("t4", 1'b0, 4'd0);

    // 5: test 1 with byte_valid toggling
    img[0] = 32'h20080005; img[1] = 32'h00000000;
    pulse_start();
    stream(8'h02, 2, 1'b0, 1'b1, -1);
    check_end("t5", 1'b0, 4'd2);

    // 6: reset after the 6th data byte, then reload with a stray start mid-load
    pulse_start();
    stream(8'h02, 2, 1'b0, 1'b0, 6);
    chk("t6_sb_first_word", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_ww", 64'(words_written), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    pulse_start();
    for (int i = 0; i < 2; i++) exp_q.push_back({3'(i), img[i]});
    send(8'h02, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    for (int k = 0; k < 4; k++) send(8'h00, 1'b0);
    send(8'h2D, 1'b0);
    byte_valid = 1'b0;
    check_end("t6", 1'b0, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
